// File: rtl/ram_access_ctrl.sv
// Burst initiator for a single-port RAM with fixed read latency.
// Read data returns in order through a credit-limited response FIFO.
module ram_access_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  busy,
  output logic                  done
);

  localparam int DEPTH = RD_LATENCY + 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);
  localparam int BW    = LEN_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [BW-1:0]         rem_q, rem_d;
  logic [CW-1:0]         out_q, out_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] fifo_q [2**PW];

  logic wr_beat;
  logic rd_issue;
  logic push;
  logic pop;
  logic credit;

  assign credit   = ({1'b0, out_q} + {1'b0, cnt_q})
                    < (CW+1)'(DEPTH);
  assign wr_beat  = (state_q == WRITE) && wdata_valid;
  assign rd_issue = (state_q == READ) && (rem_q != '0)
                    && credit;
  assign push     = pipe_q[RD_LATENCY-1];
  assign rsp_valid = (cnt_q != '0);
  assign pop      = rsp_valid && rsp_ready;

  assign cmd_ready   = (state_q == IDLE);
  assign wdata_ready = (state_q == WRITE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign mem_wr_en   = wr_beat;
  assign mem_rd_en   = rd_issue;
  assign mem_addr    = (wr_beat || rd_issue) ? cur_q : '0;
  assign mem_data_in = wr_beat ? wdata : '0;
  assign rsp_rdata   = rsp_valid ? fifo_q[rd_ptr_q] : '0;

  // Burst sequencing: address/beat counters and state transitions
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cur_d   = cmd_addr;
          rem_d   = BW'(cmd_len) + BW'(1);
          state_d = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wr_beat) begin
          cur_d = cur_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == BW'(1)) state_d = IDLE;
        end
      end
      READ: begin
        if (rd_issue) begin
          cur_d = cur_q + 1'b1;
          rem_d = rem_q - 1'b1;
        end
        if (rem_q == '0 && out_q == '0 && cnt_q == '0)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read pipeline tracking, FIFO occupancy and done pulse
  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = rd_issue;
    for (int i = 1; i < RD_LATENCY; i++)
      pipe_d[i] = pipe_q[i-1];
    out_d = out_q + CW'(rd_issue) - CW'(push);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q;
    if (push)
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1))
                 ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = rd_ptr_q;
    if (pop)
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1))
                 ? '0 : rd_ptr_q + 1'b1;
    done_d = (state_q != IDLE) && (state_d == IDLE);
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      rem_q    <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pipe_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      rem_q    <= rem_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pipe_q   <= pipe_d;
      done_q   <= done_d;
    end
  end

  // Response FIFO storage captures RAM data at its latency slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**PW; i++)
        fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wr_ptr_q] <= mem_data_out;
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Randomized scoreboard bench for ram_access_ctrl.
// Includes a latency-1 RAM model and a shadow memory reference.
module tb_ram_access_ctrl;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          wdata_valid = 1'b0;
  logic          wdata_ready;
  logic [DW-1:0] wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic          mem_rd_en;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;
  logic          busy;
  logic          done;

  ram_access_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .LEN_WIDTH(LW), .RD_LATENCY(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_rd_en(mem_rd_en), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // RAM with one cycle read latency
  logic [DW-1:0] ram [NW];
  logic [DW-1:0] ram_rd;
  assign mem_data_out = ram_rd;
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr] <= mem_data_in;
    if (mem_rd_en) ram_rd <= ram[mem_addr];
  end

  logic [DW-1:0] shadow [NW];
  logic [DW-1:0] rexp [$];
  logic [AW-1:0] wexp_a [$];
  logic [DW-1:0] wexp_d [$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int acc_cyc = 0;
  int first_rsp = -1;
  int last_rsp = -1;
  int rr_mode = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0: rsp_ready = 1'b1;
      1: rsp_ready = ($urandom_range(0, 2) != 0);
      default: rsp_ready = 1'b0;
    endcase
  end

  // Monitor: pops expected responses and writes
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_wr_en && mem_rd_en)
        chk("strobe_overlap", 1, 0);
      if (!mem_wr_en && !mem_rd_en)
        chk("mem_addr_idle", 64'(mem_addr), 0);
      if (mem_rd_en) rd_cnt++;
      if (mem_wr_en) begin
        wr_cnt++;
        if (wexp_a.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          chk("wr_addr", 64'(mem_addr),
              64'(wexp_a.pop_front()));
          chk("wr_data", 64'(mem_data_in),
              64'(wexp_d.pop_front()));
        end
      end
      if (rsp_valid) begin
        if (first_rsp < 0) first_rsp = cyc;
        last_rsp = cyc;
      end else begin
        chk("rdata_empty", 64'(rsp_rdata), 0);
      end
      if (rsp_valid && rsp_ready) begin
        if (rexp.size() == 0)
          chk("unexpected_rsp", 1, 0);
        else
          chk("rsp_data", 64'(rsp_rdata),
              64'(rexp.pop_front()));
      end
      if (done) done_cnt++;
    end
  end

  task automatic send_cmd(input bit wr,
                          input int addr,
                          input int len);
    int g = 0;
    while (!cmd_ready && g < 300) begin
      @(posedge clk); #1; g++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = AW'(addr);
    cmd_len   = LW'(len);
    acc_cyc   = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    int prev = done_cnt;
    while (done_cnt == prev && g < 400) begin
      @(posedge clk); #1; g++;
    end
    exp_done++;
    chk("done_seen", 64'(done_cnt - prev), 1);
  endtask

  // mode 0: always valid, 1: toggling, 2: random
  task automatic write_burst(input int addr,
                             input int len,
                             input int mode,
                             output bit cr_seen);
    int k = 0;
    int g = 0;
    bit ph = 1'b1;
    logic [DW-1:0] d;
    cr_seen = 1'b0;
    send_cmd(1'b1, addr, len);
    while (k <= len && g < 400) begin
      d = $urandom;
      case (mode)
        0: wdata_valid = 1'b1;
        1: wdata_valid = ph;
        default: wdata_valid = ($urandom_range(0, 3) != 0);
      endcase
      ph = ~ph;
      wdata = d;
      if (cmd_ready) cr_seen = 1'b1;
      if (wdata_valid && wdata_ready) begin
        wexp_a.push_back(AW'((addr + k) % NW));
        wexp_d.push_back(d);
        shadow[(addr + k) % NW] = d;
        k++;
      end
      @(posedge clk); #1; g++;
    end
    wdata_valid = 1'b0;
    wait_done();
  endtask

  task automatic read_burst(input int addr,
                            input int len,
                            input bit wt);
    for (int i = 0; i <= len; i++)
      rexp.push_back(shadow[(addr + i) % NW]);
    send_cmd(1'b0, addr, len);
    if (wt) wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit cr;
    int r0, w0, a, l;
    for (int i = 0; i < NW; i++) begin
      ram[i] = $urandom;
      shadow[i] = ram[i];
    end
    ram_rd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 1);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_wdata_ready", 64'(wdata_ready), 0);
    chk("rst_strobes", 64'({mem_wr_en, mem_rd_en}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single beat write and read back
    wexp_a.push_back(AW'(5));
    wexp_d.push_back(32'hDEADBEEF);
    shadow[5] = 32'hDEADBEEF;
    send_cmd(1'b1, 5, 0);
    wdata_valid = 1'b1;
    wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    wdata_valid = 1'b0;
    wait_done();
    read_burst(5, 0, 1'b1);

    // wrapping burst
    write_burst(14, 3, 0, cr);
    read_burst(14, 3, 1'b1);

    // full-length streaming read, latency and throughput
    rr_mode = 0;
    @(posedge clk); #1;
    first_rsp = -1;
    r0 = rd_cnt;
    read_burst(0, 15, 1'b1);
    chk("first_rsp_latency",
        64'(first_rsp - acc_cyc), 3);
    chk("rsp_span", 64'(last_rsp - first_rsp), 15);
    chk("rd_en_count16", 64'(rd_cnt - r0), 16);

    // back-pressure limits issued reads
    rr_mode = 2;
    @(posedge clk); #1;
    r0 = rd_cnt;
    read_burst(3, 7, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("stall_issues", 64'(rd_cnt - r0), 3);
    rr_mode = 0;
    wait_done();
    chk("stall_drained", 64'(rexp.size()), 0);

    // toggling write valid
    w0 = wr_cnt;
    write_burst(9, 3, 1, cr);
    chk("toggle_wr_pulses", 64'(wr_cnt - w0), 4);
    chk("toggle_cmd_ready_low", 64'(cr), 0);
    read_burst(9, 3, 1'b1);

    // reset in the middle of a read burst
    rr_mode = 2;
    @(posedge clk); #1;
    read_burst(0, 15, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 1);
    chk("mid_rst_rd_en", 64'(mem_rd_en), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    rexp.delete();
    rr_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_no_stale", 64'(rsp_valid), 0);
    read_burst(6, 2, 1'b1);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      rr_mode = $urandom_range(0, 1);
      a = $urandom_range(0, NW - 1);
      l = $urandom_range(0, 15);
      if ($urandom_range(0, 1) != 0)
        write_burst(a, l, 2, cr);
      else
        read_burst(a, l, 1'b1);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("rexp_empty", 64'(rexp.size()), 0);
    chk("wexp_empty", 64'(wexp_a.size()), 0);
    chk("done_total", 64'(done_cnt), 64'(exp_done));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
